// File: rtl/sck_shift_tx.sv
// SPI mode-0 word transmitter paced by an external divided clock (sck), with a one-word holding register.
// Optional feature macro: SCK_TX_PARITY_EN appends one even-parity bit (^word) after each word.
module sck_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cs_n,
  output logic             sck_out,
  output logic             mosi,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH + 1);
`ifdef SCK_TX_PARITY_EN
  localparam logic [IDX_W-1:0] LOAD_IDX = IDX_W'(WIDTH);
`else
  localparam logic [IDX_W-1:0] LOAD_IDX = IDX_W'(WIDTH - 1);
`endif
  localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sck_q;
  logic              r_hold_valid;
  logic [WIDTH-1:0]  r_hold;
  logic [WIDTH-1:0]  r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_cs_n;
  logic              r_mosi;
  logic              r_sck_out;
`ifdef SCK_TX_PARITY_EN
  logic              r_par;
`endif

  logic              w_fall;
  logic              w_accept;
  logic              w_load;
  logic [IDX_W-1:0]  w_idx_m1;
  logic [IDX_W-1:0]  w_sel;
  logic              w_next_bit;
  logic [IDX_W-1:0]  w_bit_idx_nxt;
  logic              w_cs_n_nxt;
  logic              w_mosi_nxt;
  logic              w_sck_out_nxt;

  assign w_fall   = ~sck & r_sck_q;
  assign w_accept = in_valid & ~r_hold_valid;
  assign w_idx_m1 = r_bit_idx - IDX_W'(1);

  // The parity slot sits at index 0, so data bit k is driven while the index is k+1.
`ifdef SCK_TX_PARITY_EN
  assign w_sel      = w_idx_m1 - IDX_W'(1);
  assign w_next_bit = (w_idx_m1 == '0) ? r_par : |(r_shift & (ONE_HOT0 << w_sel));
`else
  assign w_sel      = w_idx_m1;
  assign w_next_bit = |(r_shift & (ONE_HOT0 << w_sel));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && r_hold_valid) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_fall && (r_bit_idx == '0)) begin
          if (r_hold_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_bit_idx_nxt = r_bit_idx;
    w_cs_n_nxt    = r_cs_n;
    w_mosi_nxt    = r_mosi;
    if (w_load) begin
      w_bit_idx_nxt = LOAD_IDX;
      w_cs_n_nxt    = 1'b0;
      w_mosi_nxt    = r_hold[WIDTH-1];
    end else if ((r_state == S_SHIFT) && w_fall) begin
      if (r_bit_idx != '0) begin
        w_bit_idx_nxt = w_idx_m1;
        w_mosi_nxt    = w_next_bit;
      end else begin
        w_cs_n_nxt = 1'b1;
        w_mosi_nxt = 1'b0;
      end
    end
    w_sck_out_nxt = sck & (w_state_nxt == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_q      <= 1'b0;
      r_hold_valid <= 1'b0;
      r_bit_idx    <= '0;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_sck_out    <= 1'b0;
    end else begin
      r_sck_q   <= sck;
      r_bit_idx <= w_bit_idx_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_mosi    <= w_mosi_nxt;
      r_sck_out <= w_sck_out_nxt;
      // A load needs hold_valid=1, which blocks an accept in the same cycle.
      if (w_accept) begin
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= in_data;
    end
    if (w_load) begin
      r_shift <= r_hold;
`ifdef SCK_TX_PARITY_EN
      r_par   <= ^r_hold;
`endif
    end
  end

  assign in_ready = ~r_hold_valid;
  assign cs_n     = r_cs_n;
  assign sck_out  = r_sck_out;
  assign mosi     = r_mosi;
  assign busy     = r_hold_valid | (r_state == S_SHIFT);

endmodule

// File: tb/tb_sck_shift_tx.sv
// Bench for sck_shift_tx: directed and random words, checked against a bit-stream and frame model.
// Honours SCK_TX_PARITY_EN when the bench is built with the same define as the design.
module tb_sck_shift_tx;

  localparam int WIDTH = 8;
`ifdef SCK_TX_PARITY_EN
  localparam int BPW = WIDTH + 1;
`else
  localparam int BPW = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             sck;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             cs_n;
  logic             sck_out;
  logic             mosi;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  bit exp_bits[$];
  int frames[$];
  int cur_bits = 0;

  sck_shift_tx #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cs_n     (cs_n),
    .sck_out  (sck_out),
    .mosi     (mosi),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 18-clk sck period; edges land on clk falling edges, away from the sampling edge.
  initial begin
    sck = 1'b0;
    forever #90 sck = ~sck;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a transmitted word is its bits MSB first, plus even parity when enabled.
  task automatic model_push(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef SCK_TX_PARITY_EN
    exp_bits.push_back(^w);
`endif
  endtask

  // Receiver: sample mosi on sck_out rising edges inside a frame; log frame sizes.
  initial begin
    logic prev_sck_out = 1'b0;
    logic prev_cs_n    = 1'b1;
    bit   eb;
    forever begin
      @(negedge clk);
      if (!cs_n && sck_out && !prev_sck_out) begin
        if (exp_bits.size() == 0) begin
          check("extra_bit", 32'd1, 32'd0);
        end else begin
          eb = exp_bits.pop_front();
          check("mosi_bit", {31'd0, mosi}, {31'd0, eb});
        end
        cur_bits++;
      end
      if (cs_n && !prev_cs_n) begin
        frames.push_back(cur_bits);
        cur_bits = 0;
        check("end_mosi", {31'd0, mosi}, 32'd0);
        check("end_sck_out", {31'd0, sck_out}, 32'd0);
      end
      prev_sck_out = sck_out;
      prev_cs_n    = cs_n;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, (n < 2000)}, 32'd1);
    @(posedge clk);
    model_push(w);
    @(negedge clk);
    check("ready_after_accept", {31'd0, in_ready}, 32'd0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic release_valid();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cs_n && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, (n < 3000)}, 32'd1);
    repeat (2) @(negedge clk);
    check("bits_left", exp_bits.size(), 32'd0);
  endtask

  task automatic check_frames(input string tag, input int n_frames, input int bits0);
    check(tag, frames.size(), n_frames);
    if (frames.size() > 0) check(tag, frames[0], bits0);
    frames.delete();
  endtask

  initial begin
    int n;
    int total;
    logic [WIDTH-1:0] w;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;

    // Reset state while sck toggles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sck_out", {31'd0, sck_out}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_cs_n", {31'd0, cs_n}, 32'd1);
    check("idle_sck_out", {31'd0, sck_out}, 32'd0);

    // Single word
    send(8'hA5);
    release_valid();
    wait_idle();
    check_frames("frame_a5", 1, BPW);

    // Back-to-back pair in one frame
    send(8'h3C);
    send(8'hC3);
    release_valid();
    wait_idle();
    check_frames("frame_pair", 1, 2 * BPW);

    // in_valid held high for four more words while the first shifts
    send(8'($urandom));
    release_valid();
    n = 0;
    while (cs_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cs_low_timeout", {31'd0, (n < 200)}, 32'd1);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    release_valid();
    wait_idle();
    check_frames("frame_five", 1, 5 * BPW);

    // Random words with random gaps
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        release_valid();
        repeat ($urandom_range(1, 60)) @(negedge clk);
      end
    end
    release_valid();
    wait_idle();
    total = 0;
    foreach (frames[i]) total += frames[i];
    check("random_total_bits", total, 8 * BPW);
    frames.delete();

    // Reset pulsed mid-word, then a clean word
    send(8'hFF);
    release_valid();
    n = 0;
    while (cur_bits < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("bit3_timeout", {31'd0, (n < 500)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    check("midrst_sck_out", {31'd0, sck_out}, 32'd0);
    check("midrst_mosi", {31'd0, mosi}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    exp_bits.delete();
    frames.delete();
    cur_bits = 0;
    w = 8'h81;
    send(w);
    release_valid();
    wait_idle();
    check_frames("frame_81", 1, BPW);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
